// File: rtl/d_in_debounce_sync.sv
// ----------------------------------------------------------------------------
// d_in_debounce_sync
//
// Purpose:
//   Conditions an asynchronous, bouncy level (switch, button or external pin)
//   before it reaches the d input of a downstream flip-flop stage. The raw
//   level is first passed through a SYNC_STAGES-deep synchroniser. A small
//   two-state FSM then accepts a change of level only after the synchronised
//   value has differed from the current clean level for STABLE_CYCLES
//   consecutive enabled samples. The module also emits one-cycle rise/fall
//   strobes that coincide with the first cycle of the new clean level.
//
// Parameters:
//   SYNC_STAGES   - synchroniser depth (>= 2)
//   CNT_W         - width of the qualification counter
//   STABLE_CYCLES - enabled samples needed to accept a change
//                   (1 <= STABLE_CYCLES < 2**CNT_W)
//   RST_VAL       - reset value of the synchroniser chain and d_clean
//
// Ports:
//   clk     in  - single clock, all state updates on posedge
//   rst     in  - asynchronous reset, active low (0 = reset)
//   d_raw   in  - asynchronous raw input level
//   en      in  - sample-enable tick; tie high to sample on every clock
//   d_clean out - debounced, synchronised level (feeds the D-FF d input)
//   rise    out - one-clock pulse when d_clean goes 0->1
//   fall    out - one-clock pulse when d_clean goes 1->0
//   busy    out - high while a candidate change is being qualified
//
// All outputs come straight from flops; there is no combinational path from
// d_raw to any output.
// ----------------------------------------------------------------------------
module d_in_debounce_sync #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   CNT_W         = 16,
  parameter int   STABLE_CYCLES = 4,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  input  logic en,
  output logic d_clean,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Terminal count: a change is accepted on the sample where the counter
  // already holds STABLE_CYCLES-1, i.e. the STABLE_CYCLES-th differing sample.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   d_sync;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   d_clean_q, d_clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Synchroniser shift register: shifts every clock, independent of en, so
  // the metastability settling time is never stretched by the enable tick.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_raw};
  end

  assign d_sync = sync_q[SYNC_STAGES-1];

  // Qualification FSM. Nothing advances on en=0 cycles; the strobes default
  // low so they only ever fire on the single cycle of an acceptance.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    d_clean_d = d_clean_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (d_sync != d_clean_q) begin
            if (STABLE_CYCLES == 1) begin
              // A single sample is enough: accept without visiting WAIT.
              d_clean_d = d_sync;
              rise_d    = d_sync;
              fall_d    = ~d_sync;
            end else begin
              state_d = WAIT;
              cnt_d   = ONE_CNT;
            end
          end
        end

        WAIT: begin
          if (d_sync == d_clean_q) begin
            // Input went back before qualifying: treat it as a glitch.
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == LAST_CNT) begin
            state_d   = IDLE;
            cnt_d     = '0;
            d_clean_d = d_sync;
            rise_d    = d_sync;
            fall_d    = ~d_sync;
          end else begin
            cnt_d = cnt_q + ONE_CNT;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset; a reset discards any
  // qualification in progress and restarts the synchroniser from RST_VAL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= {SYNC_STAGES{RST_VAL}};
      state_q   <= IDLE;
      cnt_q     <= '0;
      d_clean_q <= RST_VAL;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      d_clean_q <= d_clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign d_clean = d_clean_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  // state_q is itself a flop, so busy is a registered, glitch-free signal.
  assign busy    = (state_q == WAIT);

endmodule

// File: tb/tb_d_in_debounce_sync.sv
// ----------------------------------------------------------------------------
// tb_d_in_debounce_sync
//
// Directed bench for d_in_debounce_sync with SYNC_STAGES=2, STABLE_CYCLES=4,
// RST_VAL=0. Inputs change 1 time unit after a rising edge; outputs are
// checked 1 time unit after the edge under test. Edge numbers in the tags
// count rising edges after the stimulus of each scenario was applied.
// ----------------------------------------------------------------------------
module tb_d_in_debounce_sync;

  logic clk;
  logic rst;
  logic d_raw;
  logic en;
  logic d_clean;
  logic rise;
  logic fall;
  logic busy;

  int testCount = 0;
  int failCount = 0;

  d_in_debounce_sync #(
    .SYNC_STAGES  (2),
    .CNT_W        (16),
    .STABLE_CYCLES(4),
    .RST_VAL      (1'b0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .d_raw  (d_raw),
    .en     (en),
    .d_clean(d_clean),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy)
  );

  // Free-running clock, period 10, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives the data and enable inputs.
  task automatic applyStimulus(input logic raw, input logic enable);
    d_raw = raw;
    en    = enable;
  endtask

  // Advances n rising edges and settles 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1);

    // Scenario 1: asynchronous reset asserted between edges, checked before
    // the first rising edge ever occurs.
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_d_clean", d_clean, 1'b0);
    checkOutput("reset_rise", rise, 1'b0);
    checkOutput("reset_fall", fall, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(3);
    checkOutput("idle_d_clean", d_clean, 1'b0);
    checkOutput("idle_busy", busy, 1'b0);

    // Scenario 2: clean rise, d_clean and rise at edge 6, busy on edges 3..5.
    applyStimulus(1'b1, 1'b1);
    tick(2);
    checkOutput("rise_e2_busy", busy, 1'b0);
    checkOutput("rise_e2_d_clean", d_clean, 1'b0);
    for (int e = 3; e <= 5; e++) begin
      tick(1);
      checkOutput($sformatf("rise_e%0d_busy", e), busy, 1'b1);
      checkOutput($sformatf("rise_e%0d_d_clean", e), d_clean, 1'b0);
      checkOutput($sformatf("rise_e%0d_rise", e), rise, 1'b0);
    end
    tick(1);
    checkOutput("rise_e6_d_clean", d_clean, 1'b1);
    checkOutput("rise_e6_rise", rise, 1'b1);
    checkOutput("rise_e6_fall", fall, 1'b0);
    checkOutput("rise_e6_busy", busy, 1'b0);
    tick(1);
    checkOutput("rise_e7_rise", rise, 1'b0);
    checkOutput("rise_e7_d_clean", d_clean, 1'b1);

    // Scenario 6: fall from d_clean=1, fall strobe at edge 6 only.
    applyStimulus(1'b0, 1'b1);
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      checkOutput($sformatf("fall_e%0d_d_clean", e), d_clean, 1'b1);
      checkOutput($sformatf("fall_e%0d_fall", e), fall, 1'b0);
      checkOutput($sformatf("fall_e%0d_rise", e), rise, 1'b0);
    end
    tick(1);
    checkOutput("fall_e6_d_clean", d_clean, 1'b0);
    checkOutput("fall_e6_fall", fall, 1'b1);
    checkOutput("fall_e6_rise", rise, 1'b0);
    tick(1);
    checkOutput("fall_e7_fall", fall, 1'b0);
    checkOutput("fall_e7_rise", rise, 1'b0);
    tick(2);

    // Scenario 3: d_raw high for only 3 clocks reaches a count of 3 and is
    // then rejected; nothing changes on the output side.
    applyStimulus(1'b1, 1'b1);
    tick(3);
    applyStimulus(1'b0, 1'b1);
    tick(1);
    checkOutput("glitch_e4_busy", busy, 1'b1);
    tick(1);
    checkOutput("glitch_e5_busy", busy, 1'b1);
    for (int e = 6; e <= 9; e++) begin
      tick(1);
      checkOutput($sformatf("glitch_e%0d_busy", e), busy, 1'b0);
      checkOutput($sformatf("glitch_e%0d_d_clean", e), d_clean, 1'b0);
      checkOutput($sformatf("glitch_e%0d_rise", e), rise, 1'b0);
      checkOutput($sformatf("glitch_e%0d_fall", e), fall, 1'b0);
    end

    // Scenario 4: en high only before edges 4, 8, 12, 16. d_sync is 1 from
    // the edge-3 sample on, so WAIT starts at edge 4 and accepts at edge 16.
    for (int e = 1; e <= 16; e++) begin
      applyStimulus(1'b1, (e % 4) == 0);
      tick(1);
      checkOutput($sformatf("engate_e%0d_d_clean", e), d_clean, e >= 16);
      checkOutput($sformatf("engate_e%0d_busy", e), busy, (e >= 4) && (e < 16));
      checkOutput($sformatf("engate_e%0d_rise", e), rise, e == 16);
    end
    applyStimulus(1'b1, 1'b0);
    tick(1);
    checkOutput("engate_e17_rise", rise, 1'b0);
    checkOutput("engate_e17_d_clean", d_clean, 1'b1);

    // Scenario 5: reset while a rise is being qualified, then release with
    // d_raw=1 held; the full 6-edge latency applies again.
    applyStimulus(1'b0, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("rst_pre_d_clean", d_clean, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(3);
    applyStimulus(1'b1, 1'b1);
    tick(4);
    checkOutput("rstwait_busy_before", busy, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("rstwait_busy_now", busy, 1'b0);
    checkOutput("rstwait_d_clean_now", d_clean, 1'b0);
    tick(2);
    checkOutput("rstwait_busy_held", busy, 1'b0);
    rst = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      checkOutput($sformatf("rstrel_e%0d_d_clean", e), d_clean, 1'b0);
      checkOutput($sformatf("rstrel_e%0d_rise", e), rise, 1'b0);
      checkOutput($sformatf("rstrel_e%0d_busy", e), busy, e >= 3);
    end
    tick(1);
    checkOutput("rstrel_e6_d_clean", d_clean, 1'b1);
    checkOutput("rstrel_e6_rise", rise, 1'b1);
    checkOutput("rstrel_e6_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
